// File: rtl/instr_decode_stage.sv
// Decode stage: splits raw instruction words into fields and control, holds them in a
// valid/ready output register, and stalls fetch on read-after-write hazards.
module instr_decode_stage #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned HAZ_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [3:0]      out_op,
    output logic [5:0]      out_rd,
    output logic [5:0]      out_rs,
    output logic [5:0]      out_rt,
    output logic [XLEN-1:0] out_imm,
    output logic            out_reg_write,
    output logic            out_mem_read,
    output logic            out_mem_write,
    output logic            out_branch,
    output logic            out_use_imm,
    output logic            out_illegal
);

    localparam logic [3:0] OpNop  = 4'b0000;
    localparam logic [3:0] OpIll1 = 4'b0001;
    localparam logic [3:0] OpIll2 = 4'b0010;
    localparam logic [3:0] OpSt   = 4'b0011;
    localparam logic [3:0] OpAdd  = 4'b0100;
    localparam logic [3:0] OpInc  = 4'b0101;
    localparam logic [3:0] OpNeg  = 4'b0110;
    localparam logic [3:0] OpSub  = 4'b0111;
    localparam logic [3:0] OpJ    = 4'b1000;
    localparam logic [3:0] OpBrz  = 4'b1001;
    localparam logic [3:0] OpJm   = 4'b1010;
    localparam logic [3:0] OpBrn  = 4'b1011;
    localparam logic [3:0] OpIll3 = 4'b1100;
    localparam logic [3:0] OpIll4 = 4'b1101;
    localparam logic [3:0] OpLd   = 4'b1110;
    localparam logic [3:0] OpSvpc = 4'b1111;

    logic [3:0]      dec_op;
    logic [5:0]      dec_rd;
    logic [5:0]      dec_rs;
    logic [5:0]      dec_rt;
    logic [XLEN-1:0] dec_imm;
    logic            dec_reg_write;
    logic            dec_mem_read;
    logic            dec_mem_write;
    logic            dec_branch;
    logic            dec_use_imm;
    logic            dec_illegal;
    logic            dec_rs_used;
    logic            dec_rt_used;

    logic            haz;
    logic            accept;

    logic            out_valid_q;
    logic [XLEN-1:0] out_pc_q;
    logic [3:0]      out_op_q;
    logic [5:0]      out_rd_q;
    logic [5:0]      out_rs_q;
    logic [5:0]      out_rt_q;
    logic [XLEN-1:0] out_imm_q;
    logic            out_reg_write_q;
    logic            out_mem_read_q;
    logic            out_mem_write_q;
    logic            out_branch_q;
    logic            out_use_imm_q;
    logic            out_illegal_q;

    logic [HAZ_DEPTH-1:0] pend_valid_q;
    logic [5:0]           pend_rd_q [HAZ_DEPTH];

    assign dec_op = in_instr[31:28];
    assign dec_rd = in_instr[27:22];
    assign dec_rs = in_instr[21:16];
    assign dec_rt = in_instr[15:10];

    always_comb begin
        dec_imm       = '0;
        dec_reg_write = 1'b0;
        dec_mem_read  = 1'b0;
        dec_mem_write = 1'b0;
        dec_branch    = 1'b0;
        dec_use_imm   = 1'b0;
        dec_illegal   = 1'b0;
        dec_rs_used   = 1'b0;
        dec_rt_used   = 1'b0;
        unique case (dec_op)
            OpNop: ;
            OpSvpc: begin
                dec_imm       = {{(XLEN-22){in_instr[21]}}, in_instr[21:0]};
                dec_use_imm   = 1'b1;
                dec_reg_write = 1'b1;
            end
            OpLd: begin
                dec_reg_write = 1'b1;
                dec_mem_read  = 1'b1;
                dec_rs_used   = 1'b1;
            end
            OpSt: begin
                dec_mem_write = 1'b1;
                dec_rs_used   = 1'b1;
                dec_rt_used   = 1'b1;
            end
            OpAdd, OpSub: begin
                dec_reg_write = 1'b1;
                dec_rs_used   = 1'b1;
                dec_rt_used   = 1'b1;
            end
            OpInc: begin
                // rt field doubles as the 6-bit increment, so it is not a source here
                dec_imm       = {{(XLEN-6){in_instr[15]}}, in_instr[15:10]};
                dec_use_imm   = 1'b1;
                dec_reg_write = 1'b1;
                dec_rs_used   = 1'b1;
            end
            OpNeg: begin
                dec_reg_write = 1'b1;
                dec_rs_used   = 1'b1;
            end
            OpJ, OpBrz, OpBrn: begin
                dec_branch  = 1'b1;
                dec_rs_used = 1'b1;
            end
            OpJm: begin
                dec_branch   = 1'b1;
                dec_mem_read = 1'b1;
                dec_rs_used  = 1'b1;
            end
            OpIll1, OpIll2, OpIll3, OpIll4: begin
                dec_illegal = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        haz = 1'b0;
        if (in_valid) begin
            for (int i = 0; i < int'(HAZ_DEPTH); i++) begin
                if (pend_valid_q[i] && dec_rs_used && (dec_rs == pend_rd_q[i])) haz = 1'b1;
                if (pend_valid_q[i] && dec_rt_used && (dec_rt == pend_rd_q[i])) haz = 1'b1;
            end
            if (out_valid_q && out_reg_write_q) begin
                if (dec_rs_used && (dec_rs == out_rd_q)) haz = 1'b1;
                if (dec_rt_used && (dec_rt == out_rd_q)) haz = 1'b1;
            end
        end
    end

    assign in_ready = !flush && !haz && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            out_pc_q        <= '0;
            out_op_q        <= '0;
            out_rd_q        <= '0;
            out_rs_q        <= '0;
            out_rt_q        <= '0;
            out_imm_q       <= '0;
            out_reg_write_q <= 1'b0;
            out_mem_read_q  <= 1'b0;
            out_mem_write_q <= 1'b0;
            out_branch_q    <= 1'b0;
            out_use_imm_q   <= 1'b0;
            out_illegal_q   <= 1'b0;
        end else if (flush) begin
            out_valid_q <= 1'b0;
        end else if (accept) begin
            out_valid_q     <= 1'b1;
            out_pc_q        <= in_pc;
            out_op_q        <= dec_op;
            out_rd_q        <= dec_rd;
            out_rs_q        <= dec_rs;
            out_rt_q        <= dec_rt;
            out_imm_q       <= dec_imm;
            out_reg_write_q <= dec_reg_write;
            out_mem_read_q  <= dec_mem_read;
            out_mem_write_q <= dec_mem_write;
            out_branch_q    <= dec_branch;
            out_use_imm_q   <= dec_use_imm;
            out_illegal_q   <= dec_illegal;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Issued writers stay pending for HAZ_DEPTH cycles; flush leaves them alone.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_valid_q <= '0;
            for (int i = 0; i < int'(HAZ_DEPTH); i++) pend_rd_q[i] <= '0;
        end else begin
            pend_valid_q[0] <= out_valid_q && out_ready && out_reg_write_q;
            pend_rd_q[0]    <= out_rd_q;
            for (int i = 1; i < int'(HAZ_DEPTH); i++) begin
                pend_valid_q[i] <= pend_valid_q[i-1];
                pend_rd_q[i]    <= pend_rd_q[i-1];
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_pc        = out_pc_q;
    assign out_op        = out_op_q;
    assign out_rd        = out_rd_q;
    assign out_rs        = out_rs_q;
    assign out_rt        = out_rt_q;
    assign out_imm       = out_imm_q;
    assign out_reg_write = out_reg_write_q;
    assign out_mem_read  = out_mem_read_q;
    assign out_mem_write = out_mem_write_q;
    assign out_branch    = out_branch_q;
    assign out_use_imm   = out_use_imm_q;
    assign out_illegal   = out_illegal_q;

endmodule
